// File: rtl/moter_pwm_ramp_ctrl_pkg.sv
// moter_pkg: state codes, H-bridge drive codes and the speed-to-duty target helper
package moter_pkg;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RAMP_UP   = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_DEF_ON    = 3'd3;
    localparam logic [2:0] S_DEF_OFF   = 3'd4;
    localparam logic [2:0] S_RAMP_DOWN = 3'd5;
    localparam logic [2:0] S_BRAKE     = 3'd6;
    localparam logic [1:0] MC_COAST = 2'b00;
    localparam logic [1:0] MC_FWD   = 2'b10;
    localparam logic [1:0] MC_REV   = 2'b01;
    localparam logic [1:0] MC_BRAKE = 2'b11;
    function automatic int target_duty(input logic [1:0] sel, input int bits);
        int t;
        t = (int'(sel) + 1) << (bits - 2);
        return (t > (1 << bits) - 1) ? (1 << bits) - 1 : t;
    endfunction
endpackage

// File: rtl/moter_pwm_ramp_ctrl_pwm_gen.sv
// pwm_gen: prescaled free-running PWM counter, period-boundary pulse and registered duty compare
module pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pb,
    output logic                pwm_out
);
    logic [15:0] pre;
    logic [PWM_BITS-1:0] cnt;
    logic tick;
    assign tick = pre == 16'(PRESCALE - 1);
    assign pb = tick & (&cnt);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
            cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 16'd1;
            if (tick) cnt <= cnt + 1'b1;
            pwm_out <= cnt < duty;
        end
    end
endmodule

// File: rtl/moter_pwm_ramp_ctrl.sv
// moter_pwm_ramp_ctrl: ramped PWM motor drive with four speeds and defrost pulsing; MOTER_BRAKE_EN adds a timed BRAKE before IDLE
module moter_pwm_ramp_ctrl
    import moter_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 100,
    parameter int RAMP_STEP    = 16,
    parameter int DEFROST_DUTY = 128,
    parameter int DEF_ON_PER   = 4,
    parameter int DEF_OFF_PER  = 4,
    parameter int BRAKE_PER    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                defrost_start,
    input  logic                stop,
    input  logic [1:0]          speed_sel,
    input  logic                dir,
    output logic [1:0]          moter_control,
    output logic                pwm_out,
    output logic                busy,
    output logic [PWM_BITS-1:0] duty
);
    localparam int W = PWM_BITS + 1;
    localparam logic [W-1:0] STEP = W'(RAMP_STEP);
`ifdef MOTER_BRAKE_EN
    localparam logic [2:0] DOWN_END = S_BRAKE;
`else
    localparam logic [2:0] DOWN_END = S_IDLE;
`endif
    logic pb, dir_q, halt, dexit;
    logic [2:0] state, ns0, ns;
    logic [15:0] pc;
    logic [W-1:0] d, nd, tgt, up, dn, rd;
    pwm_gen #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_pwm (
        .clk(clk),
        .rst(rst),
        .duty(d[PWM_BITS-1:0]),
        .pb(pb),
        .pwm_out(pwm_out)
    );
    assign tgt = W'(target_duty(speed_sel, PWM_BITS));
    assign up = (d + STEP >= tgt) ? tgt : d + STEP;
    assign dn = (d > STEP) ? d - STEP : '0;
    assign rd = (dn > tgt) ? dn : tgt;
    assign halt = stop | ~start;
    assign dexit = stop | start | ~defrost_start;
    // ns0 picks the state whose duty rule applies; ns then folds in the ramp end points
    always_comb begin
        ns0 = S_IDLE;
        case (state)
            S_IDLE:      ns0 = stop ? S_IDLE : start ? S_RAMP_UP : defrost_start ? S_DEF_ON : S_IDLE;
            S_RAMP_UP:   ns0 = halt ? S_RAMP_DOWN : (d >= tgt) ? S_RUN : S_RAMP_UP;
            S_RUN:       ns0 = halt ? S_RAMP_DOWN : (tgt > d) ? S_RAMP_UP : S_RUN;
            S_DEF_ON:    ns0 = dexit ? S_RAMP_DOWN : (pc == 16'(DEF_ON_PER - 1)) ? S_DEF_OFF : S_DEF_ON;
            S_DEF_OFF:   ns0 = dexit ? S_IDLE : (pc == 16'(DEF_OFF_PER - 1)) ? S_DEF_ON : S_DEF_OFF;
            S_RAMP_DOWN: ns0 = S_RAMP_DOWN;
            S_BRAKE:     ns0 = (pc == 16'(BRAKE_PER - 1)) ? S_IDLE : S_BRAKE;
            default:     ns0 = S_IDLE;
        endcase
        nd = (ns0 == S_RAMP_UP) ? up :
             (ns0 == S_RUN) ? ((d > tgt) ? rd : d) :
             (ns0 == S_DEF_ON) ? W'(DEFROST_DUTY) :
             (ns0 == S_RAMP_DOWN) ? dn : '0;
        ns = (ns0 == S_RAMP_UP && nd == tgt) ? S_RUN :
             (ns0 == S_RAMP_DOWN && nd == '0) ? DOWN_END : ns0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            d <= '0;
            pc <= '0;
            dir_q <= 1'b0;
        end else if (pb) begin
            state <= ns;
            d <= nd;
            pc <= (ns == state) ? pc + 16'd1 : '0;
            if (state == S_IDLE) dir_q <= dir;
        end
    end
    assign busy = state != S_IDLE;
    assign duty = d[PWM_BITS-1:0];
    assign moter_control = (state == S_IDLE || state == S_DEF_OFF) ? MC_COAST :
                           (state == S_BRAKE) ? MC_BRAKE : dir_q ? MC_REV : MC_FWD;
endmodule

// File: tb/tb_moter_pwm_ramp_ctrl.sv
// tb_moter_pwm_ramp_ctrl: directed and random stimulus against a period-level model of moter_pwm_ramp_ctrl
module tb_moter_pwm_ramp_ctrl;
    localparam int STEP = 4, DDUTY = 8, MAXD = 15, PER = 32, ON_PER = 2, OFF_PER = 1, BRK_PER = 1;
`ifdef MOTER_BRAKE_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif
    typedef enum {IDLE, UP, RUN, DON, DOFF, DOWN, BRK} mode_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, defrost_start = 1'b0, stop = 1'b0, dir = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic [1:0] moter_control;
    logic pwm_out, busy;
    logic [3:0] duty;
    int passed = 0, total = 0;
    mode_t m = IDLE;
    int md = 0, ph = 0, k = 0, pbcnt = 0, mdir = 0, exp_pwm = 0;

    always #5 clk = ~clk;

    moter_pwm_ramp_ctrl #(
        .PWM_BITS(4), .PRESCALE(2), .RAMP_STEP(STEP), .DEFROST_DUTY(DDUTY),
        .DEF_ON_PER(ON_PER), .DEF_OFF_PER(OFF_PER), .BRAKE_PER(BRK_PER)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .defrost_start(defrost_start), .stop(stop),
        .speed_sel(speed_sel), .dir(dir), .moter_control(moter_control), .pwm_out(pwm_out),
        .busy(busy), .duty(duty)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int min2(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int exp_mc();
        if (m == IDLE || m == DOFF) return 0;
        if (m == BRK) return 3;
        return mdir ? 1 : 2;
    endfunction

    task automatic climb(input int tgt);
        md = min2(md + STEP, tgt);
        m = (md == tgt) ? RUN : UP;
    endtask

    task automatic go_down();
        md = max2(md - STEP, 0);
        ph = 0;
        m = (md > 0) ? DOWN : (BRK_EN ? BRK : IDLE);
    endtask

    task automatic period_end();
        int tgt;
        tgt = min2((int'(speed_sel) + 1) * 4, MAXD);
        if (m == IDLE) mdir = int'(dir);
        case (m)
            IDLE: begin
                if (!stop && start) climb(tgt);
                else if (!stop && defrost_start) begin m = DON; md = DDUTY; ph = 0; end
            end
            UP, RUN: begin
                if (stop || !start) go_down();
                else if (md < tgt) climb(tgt);
                else begin m = RUN; md = max2(md - STEP, tgt); end
            end
            DON: begin
                if (stop || start || !defrost_start) go_down();
                else begin
                    ph++;
                    if (ph == ON_PER) begin m = DOFF; md = 0; ph = 0; end
                end
            end
            DOFF: begin
                if (stop || start || !defrost_start) begin m = IDLE; md = 0; end
                else begin
                    ph++;
                    if (ph == OFF_PER) begin m = DON; md = DDUTY; ph = 0; end
                end
            end
            DOWN: go_down();
            BRK: begin
                ph++;
                if (ph == BRK_PER) m = IDLE;
            end
            default: m = IDLE;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m = IDLE; md = 0; ph = 0; k = 0; mdir = 0; exp_pwm = 0;
        end else begin
            exp_pwm = int'(((k / 2) % 16) < md);
            if (k % PER == PER - 1) begin
                period_end();
                pbcnt++;
            end
            k++;
        end
    end

    always @(negedge clk) begin
        chk("duty", int'(duty), md);
        chk("pwm_out", int'(pwm_out), exp_pwm);
        chk("busy", int'(busy), int'(m != IDLE));
        chk("moter_control", int'(moter_control), exp_mc());
    end

    task automatic wait_pb();
        int c0;
        c0 = pbcnt;
        for (int n = 0; n < 80 && pbcnt == c0; n++) @(negedge clk);
        chk("pb_reached", int'(pbcnt != c0), 1);
    endtask

    initial begin
        int hi;
        rst = 1'b0;
        #20;
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mc", int'(moter_control), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        rst = 1'b1;
        start = 1'b1; speed_sel = 2'd3; dir = 1'b0;
        wait_pb();
        chk("up_duty4", int'(duty), 4);
        chk("up_mc_fwd", int'(moter_control), 2);
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        chk("pwm_high_clks", hi, 8);
        chk("up_duty8", int'(duty), 8);
        wait_pb();
        chk("up_duty12", int'(duty), 12);
        wait_pb();
        chk("run_duty15", int'(duty), 15);
        speed_sel = 2'd1;
        wait_pb();
        chk("run_down11", int'(duty), 11);
        wait_pb();
        chk("run_down8", int'(duty), 8);
        start = 1'b0;
        wait_pb();
        chk("stop_duty4", int'(duty), 4);
        wait_pb();
        chk("stop_duty0", int'(duty), 0);
        chk("down_mc", int'(moter_control), BRK_EN ? 3 : 0);
        chk("down_busy", int'(busy), BRK_EN ? 1 : 0);
        wait_pb();
        chk("idle_busy", int'(busy), 0);
        defrost_start = 1'b1;
        wait_pb();
        chk("don_duty", int'(duty), 8);
        chk("don_mc", int'(moter_control), 2);
        wait_pb();
        chk("don_duty2", int'(duty), 8);
        wait_pb();
        chk("doff_duty", int'(duty), 0);
        chk("doff_mc", int'(moter_control), 0);
        chk("doff_busy", int'(busy), 1);
        wait_pb();
        chk("don_again", int'(duty), 8);
        wait_pb();
        wait_pb();
        chk("doff_again", int'(duty), 0);
        defrost_start = 1'b0;
        wait_pb();
        chk("def_exit_busy", int'(busy), 0);
        start = 1'b1; speed_sel = 2'd2; dir = 1'b1;
        wait_pb();
        chk("rev_mc", int'(moter_control), 1);
        dir = 1'b0;
        wait_pb();
        chk("rev_hold_mc", int'(moter_control), 1);
        wait_pb();
        chk("run12", int'(duty), 12);
        stop = 1'b1;
        wait_pb();
        chk("stopped_duty", int'(duty), 8);
        chk("stopped_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) wait_pb();
        stop = 1'b0; start = 1'b0;
        wait_pb();
        chk("stop_idle", int'(busy), 0);
        start = 1'b1; speed_sel = 2'd3; dir = 1'b0;
        wait_pb();
        wait_pb();
        chk("pre_rst_duty", int'(duty), 8);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_duty", int'(duty), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_mc", int'(moter_control), 0);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) start = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) defrost_start = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) dir = 1'($urandom_range(0, 1));
            if (!stop && $urandom_range(0, 399) == 0) stop = 1'b1;
            else if (stop && $urandom_range(0, 39) == 0) stop = 1'b0;
            if ($urandom_range(0, 2999) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
